// File: rtl/start_stop_pulse_gen_pkg.sv
// Shared types and helpers for the TDC start/stop stimulus generator.
package start_stop_pulse_gen_pkg;

  localparam int unsigned NSTOP_DEFAULT = 8;
  localparam int unsigned DW_DEFAULT    = 8;
  localparam int unsigned WW_DEFAULT    = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StDelay = 3'd2,
    StStop  = 3'd3,
    StGap   = 3'd4,
    StFin   = 3'd5
  } state_e;

  // Lower-bound clamp used to derive effective pulse width, delay and step.
  function automatic logic [31:0] max_clamp(input logic [31:0] a, input logic [31:0] floor_v);
    return (a > floor_v) ? a : floor_v;
  endfunction

endpackage

// File: rtl/start_stop_pulse_gen_pulse_timer.sv
// Loadable down-counter shared by every timed FSM state; zero marks the last cycle of a state.
module pulse_timer #(
  parameter int unsigned CW = 9
) (
  input  logic          clk,
  input  logic          res,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          count,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/start_stop_pulse_gen.sv
// Emits one start pulse then NSTOP evenly spaced stop pulses per trigger, for TDC self-test.
module start_stop_pulse_gen
  import start_stop_pulse_gen_pkg::*;
#(
  parameter int unsigned NSTOP = NSTOP_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned WW    = WW_DEFAULT
) (
  input  logic             clk,
  input  logic             res,
  input  logic             trig,
  input  logic             abort,
  input  logic [NSTOP-1:0] stop_mask,
  input  logic [DW-1:0]    delay_base,
  input  logic [DW-1:0]    delay_step,
  input  logic [WW-1:0]    pulse_width,
  output logic             startpulse,
  output logic [NSTOP-1:0] stoppulse,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = DW + 1;
  localparam int unsigned KW = (NSTOP > 1) ? $clog2(NSTOP) : 1;
  localparam logic [CW-1:0] One = CW'(1);

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    w_q, d_q, s_q;
  logic [NSTOP-1:0] mask_q;
  logic             startpulse_q, busy_q, done_q;
  logic [NSTOP-1:0] stoppulse_q;

  logic [CW-1:0] w_in, d_in, s_in;
  logic [KW-1:0] k_inc;
  logic          last_stop;
  logic          timer_load, timer_count, timer_zero;
  logic [CW-1:0] timer_val;

  // Effective values are computed one bit wider than the inputs so the clamp never wraps.
  assign w_in = CW'(max_clamp(32'(pulse_width), 32'd1));
  assign d_in = CW'(max_clamp(32'(delay_base), 32'(w_in)));
  assign s_in = CW'(max_clamp(32'(delay_step), 32'(w_in)));

  assign k_inc     = k_q + KW'(1);
  assign last_stop = (k_q == KW'(NSTOP - 1));

  function automatic logic [NSTOP-1:0] chan_sel(input logic [KW-1:0] k);
    return NSTOP'(1) << k;
  endfunction

  // Timer holds (remaining cycles - 1) of the current state.
  always_comb begin
    timer_load  = 1'b0;
    timer_count = 1'b0;
    timer_val   = '0;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          timer_load = 1'b1;
          timer_val  = w_in - One;
        end
      end
      StStart: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          timer_val  = (d_q != w_q) ? (d_q - w_q - One) : (w_q - One);
        end else begin
          timer_count = 1'b1;
        end
      end
      StDelay, StGap: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          timer_val  = w_q - One;
        end else begin
          timer_count = 1'b1;
        end
      end
      StStop: begin
        if (timer_zero) begin
          if (!last_stop) begin
            timer_load = 1'b1;
            timer_val  = (s_q != w_q) ? (s_q - w_q - One) : (w_q - One);
          end
        end else begin
          timer_count = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pulse_timer #(
    .CW(CW)
  ) u_pulse_timer (
    .clk      (clk),
    .res      (res),
    .load     (timer_load),
    .load_val (timer_val),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= StIdle;
      k_q          <= '0;
      w_q          <= '0;
      d_q          <= '0;
      s_q          <= '0;
      mask_q       <= '0;
      startpulse_q <= 1'b0;
      stoppulse_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q      <= StIdle;
        startpulse_q <= 1'b0;
        stoppulse_q  <= '0;
        busy_q       <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (trig) begin
              state_q      <= StStart;
              startpulse_q <= 1'b1;
              busy_q       <= 1'b1;
              k_q          <= '0;
              w_q          <= w_in;
              d_q          <= d_in;
              s_q          <= s_in;
              mask_q       <= stop_mask;
            end
          end
          StStart: begin
            if (timer_zero) begin
              startpulse_q <= 1'b0;
              if (d_q != w_q) begin
                state_q <= StDelay;
              end else begin
                state_q     <= StStop;
                stoppulse_q <= mask_q & chan_sel(k_q);
              end
            end
          end
          StDelay, StGap: begin
            if (timer_zero) begin
              state_q     <= StStop;
              stoppulse_q <= mask_q & chan_sel(k_q);
            end
          end
          StStop: begin
            if (timer_zero) begin
              stoppulse_q <= '0;
              if (last_stop) begin
                state_q <= StFin;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                k_q <= k_inc;
                if (s_q != w_q) begin
                  state_q <= StGap;
                end else begin
                  // Back-to-back slots: hand the pulse straight to the next channel.
                  stoppulse_q <= mask_q & chan_sel(k_inc);
                end
              end
            end
          end
          StFin: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign startpulse = startpulse_q;
  assign stoppulse  = stoppulse_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_start_stop_pulse_gen.sv
// Directed self-checking bench for start_stop_pulse_gen.
module tb_start_stop_pulse_gen;

  localparam int unsigned NSTOP = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 4;

  logic             clk = 1'b0;
  logic             res = 1'b0;
  logic             trig = 1'b0;
  logic             abort = 1'b0;
  logic [NSTOP-1:0] stop_mask = '0;
  logic [DW-1:0]    delay_base = '0;
  logic [DW-1:0]    delay_step = '0;
  logic [WW-1:0]    pulse_width = '0;
  logic             startpulse;
  logic [NSTOP-1:0] stoppulse;
  logic             busy;
  logic             done;

  logic [NSTOP+2:0] obs;
  logic [NSTOP+2:0] expv;
  int n_checks = 0;
  int n_fail   = 0;

  assign obs = {startpulse, stoppulse, busy, done};

  always #5 clk = ~clk;

  start_stop_pulse_gen #(
    .NSTOP(NSTOP),
    .DW   (DW),
    .WW   (WW)
  ) dut (
    .clk        (clk),
    .res        (res),
    .trig       (trig),
    .abort      (abort),
    .stop_mask  (stop_mask),
    .delay_base (delay_base),
    .delay_step (delay_step),
    .pulse_width(pulse_width),
    .startpulse (startpulse),
    .stoppulse  (stoppulse),
    .busy       (busy),
    .done       (done)
  );

  // Expected {startpulse, stoppulse, busy, done} at cycle n of a burst with t0 = 1,
  // given effective W, D, S.
  function automatic logic [NSTOP+2:0] exp_out(input int n, input int w, input int d,
                                               input int s, input logic [NSTOP-1:0] m);
    logic [NSTOP-1:0] st;
    int done_c;
    int rise;
    done_c = 1 + d + (int'(NSTOP) - 1) * s + w;
    st = '0;
    for (int k = 0; k < int'(NSTOP); k++) begin
      rise  = 1 + d + k * s;
      st[k] = m[k] && (n >= rise) && (n < rise + w);
    end
    return {(n >= 1) && (n <= w), st, (n >= 1) && (n < done_c), n == done_c};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, {(NSTOP+3){1'b0}});
    end
    res = 1'b1;
  endtask

  task automatic test_basic();
    pulse_width = 4'd2; delay_base = 8'd10; delay_step = 8'd5; stop_mask = 8'hFF;
    for (int n = 0; n <= 52; n++) begin
      @(negedge clk);
      expv = exp_out(n, 2, 10, 5, 8'hFF);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL basic cycle %0d: got %b expected %b", n, obs, expv);
      end
      trig = (n == 0);
    end
  endtask

  task automatic test_mask_clamp();
    pulse_width = 4'd0; delay_base = 8'd0; delay_step = 8'd0; stop_mask = 8'hA5;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      expv = exp_out(n, 1, 1, 1, 8'hA5);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL mask_clamp cycle %0d: got %b expected %b", n, obs, expv);
      end
      trig = (n == 0);
    end
  endtask

  task automatic test_mask_zero();
    pulse_width = 4'd1; delay_base = 8'd3; delay_step = 8'd2; stop_mask = 8'h00;
    for (int n = 0; n <= 22; n++) begin
      @(negedge clk);
      expv = exp_out(n, 1, 3, 2, 8'h00);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL mask_zero cycle %0d: got %b expected %b", n, obs, expv);
      end
      trig = (n == 0);
    end
  endtask

  task automatic test_abort();
    pulse_width = 4'd2; delay_base = 8'd10; delay_step = 8'd5; stop_mask = 8'hFF;
    for (int n = 0; n <= 75; n++) begin
      @(negedge clk);
      if (n <= 20)      expv = exp_out(n, 2, 10, 5, 8'hFF);
      else if (n <= 22) expv = '0;
      else              expv = exp_out(n - 22, 2, 10, 5, 8'hFF);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL abort cycle %0d: got %b expected %b", n, obs, expv);
      end
      trig  = (n == 0) || (n == 22);
      abort = (n == 20);
    end
  endtask

  task automatic test_reset_mid_and_ignored_trig();
    pulse_width = 4'd2; delay_base = 8'd10; delay_step = 8'd5; stop_mask = 8'hFF;
    for (int n = 0; n <= 14; n++) begin
      @(negedge clk);
      expv = exp_out(n, 2, 10, 5, 8'hFF);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL reset_mid pre cycle %0d: got %b expected %b", n, obs, expv);
      end
      trig = (n == 0);
    end
    res = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid async_clear: got %b expected %b", obs, {(NSTOP+3){1'b0}});
    end
    @(negedge clk);
    res = 1'b1;
    for (int n = 0; n <= 55; n++) begin
      @(negedge clk);
      expv = exp_out(n, 2, 10, 5, 8'hFF);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL ignored_trig cycle %0d: got %b expected %b", n, obs, expv);
      end
      trig = (n == 0) || (n == 5) || (n == 30) || (n == 48);
    end
  endtask

  task automatic test_max();
    pulse_width = 4'd15; delay_base = 8'd255; delay_step = 8'd255; stop_mask = 8'hFF;
    for (int n = 0; n <= 2060; n++) begin
      @(negedge clk);
      expv = exp_out(n, 15, 255, 255, 8'hFF);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL max cycle %0d: got %b expected %b", n, obs, expv);
      end
      trig = (n == 0);
    end
  endtask

  task automatic test_config_change();
    pulse_width = 4'd2; delay_base = 8'd10; delay_step = 8'd5; stop_mask = 8'h0F;
    for (int n = 0; n <= 55; n++) begin
      @(negedge clk);
      expv = exp_out(n, 2, 10, 5, 8'h0F);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL config_change cycle %0d: got %b expected %b", n, obs, expv);
      end
      trig = (n == 0);
      if (n == 1) begin
        delay_step  = 8'd1;
        stop_mask   = 8'hFF;
        pulse_width = 4'd7;
        delay_base  = 8'd3;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask_clamp();
    test_mask_zero();
    test_abort();
    test_reset_mid_and_ignored_trig();
    test_max();
    test_config_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/start_stop_pulse_gen.md
Name: start_stop_pulse_gen

Overview:
Sequential stimulus generator that drives the TDC start/stop pulse interface. It produces the other end of the pulse-combining interrupt logic.
- On a trigger it emits one start pulse, then up to NSTOP stop pulses at programmed, evenly spaced clock-cycle delays.
- Used for in-system calibration and self-test of the Chrono32C measurement path.
- Sits between the control/register block and the start/stop pulse inputs.

Parameters:
NSTOP, 8, number of stop channels (width of stoppulse and stop_mask)
DW, 8, width of delay_base and delay_step in clock cycles
WW, 4, width of pulse_width field

Ports:
clk  input  1  system clock, all logic on rising edge
res  input  1  reset, asynchronous assert, active-low (0 = reset)
trig  input  1  burst request, sampled only in IDLE
abort  input  1  synchronous abort of a running burst
stop_mask  input  NSTOP  bit k=1 enables stop channel k
delay_base  input  DW  cycles from start rising edge to stop 0 rising edge
delay_step  input  DW  cycles between consecutive stop rising edges
pulse_width  input  WW  high time of every pulse in cycles
startpulse  output  1  start pulse to TDC
stoppulse  output  NSTOP  stop pulses to TDC
busy  output  1  burst in progress
done  output  1  one-cycle strobe at burst completion

Behaviour:
- Reset (res=0), asynchronous:
  - startpulse=0, stoppulse=0, busy=0, done=0.
  - FSM goes to IDLE; all counters go to 0.
- All outputs are registered.
- Configuration latch: stop_mask, delay_base, delay_step and pulse_width are captured on the trig-accept cycle. Changes during a burst have no effect.
- Effective values:
  - W = max(pulse_width, 1).
  - D = max(delay_base, W).
  - S = max(delay_step, W).
  - Computed at DW+1 bits, so no overflow.
- Timing:
  - trig=1 in IDLE at cycle T → startpulse high on cycles T+1 .. T+W. Call T+1 = t0.
  - busy rises at t0 and stays high until the cycle done is asserted.
  - Stop k rising edge is at t0 + D + k·S, high for W cycles, k = 0..NSTOP-1.
  - A masked channel (mask bit 0) stays low, but its time slot is still consumed, so spacing never depends on the mask.
  - At most one stop output is high at a time, because S ≥ W.
  - done=1 for exactly one cycle at t0 + D + (NSTOP-1)·S + W, i.e. the cycle after the last slot ends. busy=0 on that same cycle.
- FSM states:
  - IDLE → START on trig.
  - START (W cycles) → DELAY.
  - DELAY (D−W cycles; skipped when 0) → STOP.
  - STOP (W cycles, drives stoppulse[k] if mask[k]) → GAP if k < NSTOP-1, else FIN.
  - GAP (S−W cycles; skipped when 0) → STOP with k+1.
  - FIN (1 cycle, done=1) → IDLE.
- trig while busy: ignored, not queued.
- trig on the FIN cycle: ignored. A new burst can be accepted from the cycle after done.
- abort=1 in any non-IDLE state:
  - Next cycle: all pulse outputs 0, busy=0, FSM in IDLE, done stays 0.
  - abort has priority over trig.
  - abort in IDLE has no effect.
- res asserted mid-burst: outputs are cleared immediately (asynchronously), with no done strobe.
- stop_mask all zero: start pulse is still emitted, no stops, done at the normal time.

Decomposition:
- Shared package: FSM state encoding (IDLE, START, DELAY, STOP, GAP, FIN as 3-bit constants), default parameter values, and a max-clamp function for W/D/S.
- One natural sub-module: pulse_timer, a loadable down-counter of DW+1 bits with load, count and zero flag. It is instantiated once and reused by every timed state.
- The stop-index counter and the channel decode stay in the top.

Test Plan:
1. Basic burst
   - Stimulus: pulse_width=2, delay_base=10, delay_step=5, mask=8'hFF, trig at cycle 0.
   - Required: startpulse high cycles 1–2; stop0 high 11–12, stop1 16–17, …, stop7 46–47; done at 48; busy high 1–47.
2. Masking and clamping
   - Stimulus: mask=8'hA5, pulse_width=0, delay_base=0, delay_step=0.
   - Required: W=D=S=1; only stoppulse bits 0,2,5,7 pulse, each one cycle, at t0+1+k; done at t0+9.
3. Abort mid-burst
   - Stimulus: as scenario 1, abort at cycle 20.
   - Required: cycle 21 has all outputs 0 and busy=0; no done; a new trig at cycle 22 yields startpulse at 23.
4. Reset mid-burst and ignored trig
   - Stimulus A: res low at cycle 14, async.
   - Required A: outputs 0 in the same cycle, before the next clock edge.
   - Stimulus B: after release, trig pulses while busy.
   - Required B: exactly one burst; trig asserted on the done cycle is ignored.
5. Maximum values
   - Stimulus: delay_base=255, delay_step=255, pulse_width=15.
   - Required: stop7 rises at t0+255+7·255 = t0+2040; done at t0+2055; no counter wrap.
6. Config change during burst
   - Stimulus: alter delay_step and mask after trig.
   - Required: timing and mask equal the values latched at trig.
